// File: rtl/alu_arbiter_if.sv
// Requester-side bus of alu_arbiter: two valid/ready request channels plus a shared response payload.
// The master modport is the requester side and the slave modport is the arbiter side.
interface alu_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 10
);
  logic              req_valid_0, req_valid_1;
  logic              req_ready_0, req_ready_1;
  logic [XLEN-1:0]   req_a_0,     req_a_1;
  logic [XLEN-1:0]   req_b_0,     req_b_1;
  logic [XLEN-1:0]   req_imm_0,   req_imm_1;
  logic              req_imm_en_0, req_imm_en_1;
  logic [CTRL_W-1:0] req_ctrl_0,  req_ctrl_1;

  logic              rsp_valid_0, rsp_valid_1;
  logic              rsp_ready_0, rsp_ready_1;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_n, rsp_z;

  modport master (
    output req_valid_0, req_valid_1,
    input  req_ready_0, req_ready_1,
    output req_a_0, req_a_1, req_b_0, req_b_1, req_imm_0, req_imm_1,
    output req_imm_en_0, req_imm_en_1, req_ctrl_0, req_ctrl_1,
    input  rsp_valid_0, rsp_valid_1,
    output rsp_ready_0, rsp_ready_1,
    input  rsp_data, rsp_n, rsp_z
  );

  modport slave (
    input  req_valid_0, req_valid_1,
    output req_ready_0, req_ready_1,
    input  req_a_0, req_a_1, req_b_0, req_b_1, req_imm_0, req_imm_1,
    input  req_imm_en_0, req_imm_en_1, req_ctrl_0, req_ctrl_1,
    output rsp_valid_0, rsp_valid_1,
    input  rsp_ready_0, rsp_ready_1,
    output rsp_data, rsp_n, rsp_z
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, one operation in flight.
// Optional ALU_ARB_FASTPATH_EN: accept the next request in the response-handshake cycle (RESP->EXEC).
module alu_arbiter #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [XLEN-1:0]   alu_busA,
  output logic [XLEN-1:0]   alu_busB,
  output logic [XLEN-1:0]   alu_imm,
  output logic              alu_imm_en,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]   alu_out,
  input  logic              alu_n,
  input  logic              alu_z
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   imm;
    logic              imm_en;
    logic [CTRL_W-1:0] ctrl;
  } op_t;

`ifdef ALU_ARB_FASTPATH_EN
  localparam bit FastPath = 1'b1;
`else
  localparam bit FastPath = 1'b0;
`endif

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            owner_q, owner_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_n_q, rsp_n_d;
  logic            rsp_z_q, rsp_z_d;
  op_t             op_q, op_d;

  op_t  req_op_0, req_op_1;
  logic rsp_hs;
  logic issue_ok;
  logic arb_ptr;
  logic grant;
  logic req_hs;

  assign req_op_0 = '{a: bus.req_a_0, b: bus.req_b_0, imm: bus.req_imm_0,
                      imm_en: bus.req_imm_en_0, ctrl: bus.req_ctrl_0};
  assign req_op_1 = '{a: bus.req_a_1, b: bus.req_b_1, imm: bus.req_imm_1,
                      imm_en: bus.req_imm_en_1, ctrl: bus.req_ctrl_1};

  // Arbitration: in RESP the pointer is taken as ~owner, which is what ptr becomes on acceptance.
  always_comb begin
    rsp_hs   = (state_q == RESP) && rsp_valid_q &&
               (owner_q ? bus.rsp_ready_1 : bus.rsp_ready_0);
    issue_ok = (state_q == IDLE) || (FastPath && rsp_hs);
    arb_ptr  = (state_q == RESP) ? ~owner_q : ptr_q;
    if (bus.req_valid_0 && bus.req_valid_1) begin
      grant = arb_ptr;
    end else begin
      grant = bus.req_valid_1;
    end
    req_hs = issue_ok && (bus.req_valid_0 || bus.req_valid_1);
  end

  assign bus.req_ready_0 = req_hs && !grant;
  assign bus.req_ready_1 = req_hs &&  grant;
  assign bus.rsp_valid_0 = rsp_valid_q && !owner_q;
  assign bus.rsp_valid_1 = rsp_valid_q &&  owner_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_n       = rsp_n_q;
  assign bus.rsp_z       = rsp_z_q;

  assign alu_busA   = op_q.a;
  assign alu_busB   = op_q.b;
  assign alu_imm    = op_q.imm;
  assign alu_imm_en = op_q.imm_en;
  assign alu_ctrl   = op_q.ctrl;

  always_comb begin
    // NOTE: every _d is defaulted to its _q first so no path through the case infers a latch.
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_n_d     = rsp_n_q;
    rsp_z_d     = rsp_z_q;
    op_d        = op_q;

    case (state_q)
      IDLE: begin
        if (req_hs) state_d = EXEC;
      end
      EXEC: begin
        rsp_data_d  = alu_out;
        rsp_n_d     = alu_n;
        rsp_z_d     = alu_z;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          ptr_d       = ~owner_q;
          state_d     = req_hs ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Operands are captured only on the request handshake; they hold afterwards.
    if (req_hs) begin
      op_d    = grant ? req_op_1 : req_op_0;
      owner_d = grant;
    end
  end

  // NOTE: datapath registers are reset too, so an operation in flight is fully dropped by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_n_q     <= 1'b0;
      rsp_z_q     <= 1'b0;
      op_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_n_q     <= rsp_n_d;
      rsp_z_q     <= rsp_z_d;
      op_q        <= op_d;
    end
  end

  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.req_ready_0 && bus.req_ready_1));

  a_no_ready_in_exec: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == EXEC) |-> (!bus.req_ready_0 && !bus.req_ready_1));

  a_rsp_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RESP && !rsp_hs) |=> (rsp_valid_q && $stable(rsp_data_q) && $stable(owner_q)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ADD/SUB ALU on the alu_* port.
// Handoff latency expectations follow ALU_ARB_FASTPATH_EN when the bench is built with it.
module tb_alu_arbiter;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 10;
  localparam logic [CTRL_W-1:0] CTRL_ADD = 10'd0;
  localparam logic [CTRL_W-1:0] CTRL_SUB = 10'b0100000000;
`ifdef ALU_ARB_FASTPATH_EN
  localparam logic FAST        = 1'b1;
  localparam int   EXP_HANDOFF = 2;
`else
  localparam logic FAST        = 1'b0;
  localparam int   EXP_HANDOFF = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  logic [XLEN-1:0]   alu_busA, alu_busB, alu_imm, alu_out, alu_opb;
  logic              alu_imm_en, alu_n, alu_z;
  logic [CTRL_W-1:0] alu_ctrl;

  alu_arbiter #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_busA   (alu_busA),
    .alu_busB   (alu_busB),
    .alu_imm    (alu_imm),
    .alu_imm_en (alu_imm_en),
    .alu_ctrl   (alu_ctrl),
    .alu_out    (alu_out),
    .alu_n      (alu_n),
    .alu_z      (alu_z)
  );

  always_comb begin
    alu_opb = alu_imm_en ? alu_imm : alu_busB;
    alu_out = (alu_ctrl == CTRL_SUB) ? (alu_busA - alu_opb) : (alu_busA + alu_opb);
    alu_n   = alu_out[XLEN-1];
    alu_z   = (alu_out == '0);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int ch, input logic v, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                           input logic ie, input logic [CTRL_W-1:0] c);
    if (ch == 0) begin
      bus.req_valid_0 = v; bus.req_a_0 = a; bus.req_b_0 = b;
      bus.req_imm_0 = imm; bus.req_imm_en_0 = ie; bus.req_ctrl_0 = c;
    end else begin
      bus.req_valid_1 = v; bus.req_a_1 = a; bus.req_b_1 = b;
      bus.req_imm_1 = imm; bus.req_imm_en_1 = ie; bus.req_ctrl_1 = c;
    end
  endtask

  function automatic logic ready_of(input int ch);
    return (ch == 0) ? bus.req_ready_0 : bus.req_ready_1;
  endfunction

  function automatic logic rvalid_of(input int ch);
    return (ch == 0) ? bus.rsp_valid_0 : bus.rsp_valid_1;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_rdy0"},   bus.req_ready_0, 0);
    check({tag, "_rdy1"},   bus.req_ready_1, 0);
    check({tag, "_rv0"},    bus.rsp_valid_0, 0);
    check({tag, "_rv1"},    bus.rsp_valid_1, 0);
    check({tag, "_data"},   bus.rsp_data, 0);
    check({tag, "_n"},      bus.rsp_n, 0);
    check({tag, "_z"},      bus.rsp_z, 0);
    check({tag, "_busA"},   alu_busA, 0);
    check({tag, "_busB"},   alu_busB, 0);
    check({tag, "_imm"},    alu_imm, 0);
    check({tag, "_imm_en"}, alu_imm_en, 0);
    check({tag, "_ctrl"},   alu_ctrl, 0);
  endtask

  // Entered 1 time unit after a clock edge; returns 2 units after the edge before the handshake.
  task automatic wait_ready(input int ch, input string tag);
    int waited;
    waited = 0;
    #1;
    while (!ready_of(ch) && waited < 20) begin
      @(posedge clk); #2;
      waited++;
    end
    check({tag, "_ready"}, ready_of(ch), 1);
    check({tag, "_other_ready"}, ready_of(1 - ch), 0);
  endtask

  task automatic do_op(input string tag, input int ch, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm, input logic ie,
                       input logic [CTRL_W-1:0] c, input logic [XLEN-1:0] exp_d,
                       input logic exp_n, input logic exp_z);
    drive_req(ch, 1'b1, a, b, imm, ie, c);
    wait_ready(ch, tag);
    @(posedge clk); #1;
    drive_req(ch, 1'b0, a, b, imm, ie, c);
    check({tag, "_exec_rv"}, rvalid_of(ch), 0);
    @(posedge clk); #1;
    check({tag, "_rv"},       rvalid_of(ch), 1);
    check({tag, "_rv_other"}, rvalid_of(1 - ch), 0);
    check({tag, "_data"},     bus.rsp_data, exp_d);
    check({tag, "_n"},        bus.rsp_n, exp_n);
    check({tag, "_z"},        bus.rsp_z, exp_z);
    @(posedge clk); #1;
    check({tag, "_rv_clr"},   rvalid_of(ch), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ch;
    int n;
    int cnt;

    drive_req(0, 1'b0, '0, '0, '0, 1'b0, '0);
    drive_req(1, 1'b0, '0, '0, '0, 1'b0, '0);
    bus.rsp_ready_0 = 1'b1;
    bus.rsp_ready_1 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add", 0, 32'd5, 32'd3, 32'd0, 1'b0, CTRL_ADD, 32'd8, 1'b0, 1'b0);
    check("add_busA_held", alu_busA, 5);
    do_op("imm", 0, 32'd10, 32'd99, 32'd7, 1'b1, CTRL_ADD, 32'd17, 1'b0, 1'b0);
    check("imm_en_held", alu_imm_en, 1);
    do_op("sub_z", 1, 32'd3, 32'd3, 32'd0, 1'b0, CTRL_SUB, 32'd0, 1'b0, 1'b1);
    do_op("sub_n", 1, 32'd2, 32'd7, 32'd0, 1'b0, CTRL_SUB, 32'hFFFF_FFFB, 1'b1, 1'b0);
    check("sub_ctrl_held", alu_ctrl, CTRL_SUB);

    // Round-robin: last owner was 1, so requester 0 leads.
    drive_req(0, 1'b1, 32'd100, 32'd1, 32'd0, 1'b0, CTRL_ADD);
    drive_req(1, 1'b1, 32'd200, 32'd2, 32'd0, 1'b0, CTRL_ADD);
    for (int i = 0; i < 4; i++) begin
      ch = i % 2;
      wait_ready(ch, $sformatf("rr%0d", i));
      @(posedge clk); #1;
      check($sformatf("rr%0d_exec_rdy", i), {bus.req_ready_0, bus.req_ready_1}, 0);
      @(posedge clk); #1;
      check($sformatf("rr%0d_rv", i),       rvalid_of(ch), 1);
      check($sformatf("rr%0d_rv_other", i), rvalid_of(1 - ch), 0);
      check($sformatf("rr%0d_data", i),     bus.rsp_data, (ch == 0) ? 101 : 202);
      if (i == 3) begin
        drive_req(0, 1'b0, '0, '0, '0, 1'b0, '0);
        drive_req(1, 1'b0, '0, '0, '0, 1'b0, '0);
      end
    end
    @(posedge clk); #1;
    check("rr_done_rv1", bus.rsp_valid_1, 0);

    // Backpressure on requester 0 while requester 1 waits.
    bus.rsp_ready_0 = 1'b0;
    drive_req(0, 1'b1, 32'd40, 32'd2, 32'd0, 1'b0, CTRL_ADD);
    wait_ready(0, "bp");
    @(posedge clk); #1;
    drive_req(0, 1'b0, '0, '0, '0, 1'b0, '0);
    drive_req(1, 1'b1, 32'd7, 32'd8, 32'd0, 1'b0, CTRL_ADD);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d_rv0", i),  bus.rsp_valid_0, 1);
      check($sformatf("bp%0d_data", i), bus.rsp_data, 42);
      check($sformatf("bp%0d_rdy1", i), bus.req_ready_1, 0);
      @(posedge clk); #1;
    end
    bus.rsp_ready_0 = 1'b1;
    #1;
    check("bp_accept_rdy1", bus.req_ready_1, FAST);
    @(posedge clk); #1;
    check("bp_rv0_clr", bus.rsp_valid_0, 0);
    n = 1;
    while (!bus.rsp_valid_1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    drive_req(1, 1'b0, '0, '0, '0, 1'b0, '0);
    check("handoff_cycles", n, EXP_HANDOFF);
    check("handoff_data", bus.rsp_data, 15);
    check("handoff_rv0", bus.rsp_valid_0, 0);
    @(posedge clk); #1;
    check("handoff_rv1_clr", bus.rsp_valid_1, 0);

    // Reset during EXEC drops the operation.
    drive_req(0, 1'b1, 32'h55, 32'hAA, 32'd0, 1'b0, CTRL_ADD);
    wait_ready(0, "rmid");
    @(posedge clk); #1;
    drive_req(0, 1'b0, '0, '0, '0, 1'b0, '0);
    check("rmid_busA", alu_busA, 32'h55);
    #2 rst_n = 1'b0;
    #1;
    check_reset("rmid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.rsp_valid_0 || bus.rsp_valid_1) cnt++;
    end
    check("rmid_no_rsp", cnt, 0);
    do_op("post_rst", 0, 32'd1, 32'd1, 32'd0, 1'b0, CTRL_ADD, 32'd2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational integer ALU between two requesters (e.g. execute stage and address/branch unit).
- Each requester gets valid/ready request and response channels.
- Round-robin arbitration. Operands are registered before they drive the ALU; the result and N/Z flags are registered and held until the owner accepts them.
- One operation in flight at a time.

Parameters:
- XLEN, 32, width of operands, immediate and result.
- CTRL_W, 10, width of the ALU control word ({funct7[5], funct3}-style encoding, passed through unmodified).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_0 / req_valid_1  in  1  requester i presents an operation.
- req_ready_0 / req_ready_1  out  1  arbiter accepts requester i's operation this cycle.
- req_a_0 / req_a_1  in  XLEN  operand A.
- req_b_0 / req_b_1  in  XLEN  operand B.
- req_imm_0 / req_imm_1  in  XLEN  immediate.
- req_imm_en_0 / req_imm_en_1  in  1  select immediate instead of B.
- req_ctrl_0 / req_ctrl_1  in  CTRL_W  ALU control word.
- rsp_valid_0 / rsp_valid_1  out  1  result for requester i is valid.
- rsp_ready_0 / rsp_ready_1  in  1  requester i accepts the result.
- rsp_data  out  XLEN  registered result, shared by both response channels.
- rsp_n, rsp_z  out  1  registered N/Z flags.
- alu_busA, alu_busB, alu_imm  out  XLEN  registered ALU operands.
- alu_imm_en  out  1  registered immediate select.
- alu_ctrl  out  CTRL_W  registered ALU control word.
- alu_out  in  XLEN  ALU result.
- alu_n, alu_z  in  1  ALU flags.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - State IDLE; priority pointer ptr=0 (requester 0 preferred); owner=0.
  - All req_ready_*, rsp_valid_*, rsp_data, rsp_n, rsp_z, alu_* outputs = 0.
  - alu_ctrl=0 means ADD; alu_imm_en=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = ptr if both valid; otherwise whichever single requester is valid.
  - req_ready_grant = 1 combinationally; the other ready = 0.
  - req_ready depends only on state, ptr and req_valid_*, never on payload.
  - On handshake: latch a, b, imm, imm_en, ctrl into the alu_* registers, set owner = grant, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (one cycle):
  - ALU evaluates the registered operands.
  - At the clock edge, capture alu_out/alu_n/alu_z into rsp_data/rsp_n/rsp_z, set rsp_valid_owner=1, go to RESP.
  - Both req_ready = 0.
- RESP:
  - rsp_valid_owner held; rsp_data/n/z stable; both req_ready = 0 (base build).
  - On rsp_valid_owner && rsp_ready_owner: clear rsp_valid, set ptr = ~owner, go to IDLE.
  - rsp_ready of the non-owner is ignored.
- Latency: request handshake at cycle T gives rsp_valid high from cycle T+2. Minimum issue interval is 3 cycles (base).
- alu_* registers keep their last operation's values after completion; they are not cleared.
- Width rules: operands and control pass through unchanged. Immediate selection and shift-amount truncation are the ALU's job, not the arbiter's.
- Requesters must hold valid and payload stable until ready; the arbiter latches only on the handshake cycle.
- Simultaneous events: both valid in IDLE → ptr wins. ptr updates only on response acceptance, not on grant.
- Reset mid-operation (EXEC or RESP): the operation is dropped, all outputs return to reset values immediately, and no response is produced after reset release.

Optional Feature:
- Macro ALU_ARB_FASTPATH_EN.
- Defined: in RESP, during the cycle the owner's response handshake occurs, the arbiter also evaluates requests with ptr already treated as ~owner.
  - The grantee gets req_ready=1; on that handshake, operands are latched and the FSM goes directly RESP→EXEC.
  - Back-to-back issue interval becomes 2 cycles.
  - Granting the same requester whose response is being accepted is permitted when it is the only one valid.
- Undefined: RESP always returns to IDLE; 3-cycle interval.

Test Plan:
- Single op: req0 a=5, b=3, ctrl=ADD (0), imm_en=0, accepted at T → rsp_valid_0=1 at T+2; rsp_data=8, n=0, z=0; rsp_valid_1 never asserts.
- Flags: req1 a=3, b=3, ctrl=SUB (10'b0100000000) → rsp_data=0, z=1, n=0. Then a=2, b=7 SUB → rsp_data=0xFFFFFFFB, n=1, z=0.
- Round-robin: both valid continuously after reset, each with distinct a → grant order 0,1,0,1. rsp_valid appears on the matching channel only, with the matching data.
- Backpressure: rsp_ready_0=0 for 5 cycles during RESP, req_valid_1=1 → rsp_valid_0 and rsp_data stay stable, req_ready_1=0 throughout; req1 is granted only after the rsp0 handshake.
- Reset mid-op: assert rst_n=0 during EXEC → all outputs 0 asynchronously. After release with no requests → no rsp_valid for 10 cycles; a new req0 ADD 1+1 gives 2.
- FastPath (macro defined): req0 then req1 both pending → req1 handshake in the same cycle as the rsp0 handshake; rsp_valid_1 asserts 2 cycles later. Without the macro, 3 cycles.
